// File: rtl/elevator_req_scheduler.sv
// Elevator request scheduler for a four-floor car.
// Latches floor call buttons into a pending mask, chooses a travel direction,
// drives the target floor to the car and times the door dwell at each stop.
//
// Ports
//   clk        : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req_btn    : floor call buttons, bit i = floor i, level-sampled
//   car_floor  : current floor reported by the car
//   car_stop   : car stationary at car_floor
//   rfloor     : registered target floor for the car
//   pending    : registered outstanding-request mask
//   dir_up     : registered travel direction, 1 = up
//   busy       : scheduler not idle
//   door_open  : door dwell in progress
//   served     : one-cycle pulse on the edge that enters the door state
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no work; rfloor tracks car_floor
// S_MOVE_UP   | heading to nearest pending floor above the car
// S_MOVE_DOWN | heading to nearest pending floor below the car
// S_DOOR      | door open at car_floor for DOOR_CYCLES cycles
module elevator_req_scheduler #(
    parameter int DOOR_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req_btn,
    input  logic [1:0] car_floor,
    input  logic       car_stop,
    output logic [1:0] rfloor,
    output logic [3:0] pending,
    output logic       dir_up,
    output logic       busy,
    output logic       door_open,
    output logic       served
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MOVE_UP   = 2'd1;
    localparam logic [1:0] S_MOVE_DOWN = 2'd2;
    localparam logic [1:0] S_DOOR      = 2'd3;

    localparam logic [6:0] DWELL_LAST = 7'(DOOR_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_pending;
    logic [1:0] r_rfloor;
    logic       r_dir_up;
    logic       r_served;
    logic [6:0] r_dwell;

    logic [3:0] w_above_mask;
    logic [3:0] w_below_mask;
    logic [1:0] w_near_up;
    logic [1:0] w_near_dn;
    logic       w_has_up;
    logic       w_has_dn;
    logic [3:0] w_floor_onehot;
    logic       w_arrive;
    logic       w_reload;
    logic       w_dwell_done;
    logic [1:0] w_state_nx;
    logic [1:0] w_rfloor_nx;
    logic       w_dir_nx;
    logic       w_enter_door;
    logic [3:0] w_set;
    logic [3:0] w_clr;

    // Split pending into strictly-above / strictly-below sets, then pick the
    // closest floor in each: lowest above, highest below.
    always_comb begin
        w_above_mask = '0;
        w_below_mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) > car_floor) w_above_mask[i] = r_pending[i];
            if (2'(i) < car_floor) w_below_mask[i] = r_pending[i];
        end
        w_near_up = car_floor;
        for (int i = 3; i >= 0; i--) begin
            if (w_above_mask[i]) w_near_up = 2'(i);
        end
        w_near_dn = car_floor;
        for (int i = 0; i < 4; i++) begin
            if (w_below_mask[i]) w_near_dn = 2'(i);
        end
    end

    assign w_has_up       = |w_above_mask;
    assign w_has_dn       = |w_below_mask;
    assign w_floor_onehot = 4'b0001 << car_floor;
    assign w_arrive       = car_stop && (car_floor == r_rfloor);
    assign w_reload       = req_btn[car_floor];
    assign w_dwell_done   = (r_dwell == DWELL_LAST);

    always_comb begin
        w_state_nx  = r_state;
        w_rfloor_nx = r_rfloor;
        w_dir_nx    = r_dir_up;
        case (r_state)
            S_IDLE: begin
                w_rfloor_nx = car_floor;
                if (r_pending != 4'b0000) begin
                    if (r_pending[car_floor]) begin
                        w_state_nx = S_DOOR;
                    end else if (w_has_up) begin
                        // Up wins the tie when calls exist on both sides.
                        w_state_nx  = S_MOVE_UP;
                        w_rfloor_nx = w_near_up;
                        w_dir_nx    = 1'b1;
                    end else begin
                        w_state_nx  = S_MOVE_DOWN;
                        w_rfloor_nx = w_near_dn;
                        w_dir_nx    = 1'b0;
                    end
                end
            end
            S_MOVE_UP: begin
                if (w_arrive) begin
                    w_state_nx  = S_DOOR;
                    w_rfloor_nx = car_floor;
                end else if (w_has_up) begin
                    w_rfloor_nx = w_near_up;
                end
            end
            S_MOVE_DOWN: begin
                if (w_arrive) begin
                    w_state_nx  = S_DOOR;
                    w_rfloor_nx = car_floor;
                end else if (w_has_dn) begin
                    w_rfloor_nx = w_near_dn;
                end
            end
            S_DOOR: begin
                w_rfloor_nx = car_floor;
                if (!w_reload && w_dwell_done) begin
                    if (r_dir_up && w_has_up) begin
                        w_state_nx  = S_MOVE_UP;
                        w_rfloor_nx = w_near_up;
                    end else if (!r_dir_up && w_has_dn) begin
                        w_state_nx  = S_MOVE_DOWN;
                        w_rfloor_nx = w_near_dn;
                    end else if (w_has_up) begin
                        w_state_nx  = S_MOVE_UP;
                        w_rfloor_nx = w_near_up;
                        w_dir_nx    = 1'b1;
                    end else if (w_has_dn) begin
                        w_state_nx  = S_MOVE_DOWN;
                        w_rfloor_nx = w_near_dn;
                        w_dir_nx    = 1'b0;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_enter_door = (w_state_nx == S_DOOR) && (r_state != S_DOOR);
    // A call for the floor whose door is open is absorbed by the dwell reload.
    assign w_set = req_btn & ~((r_state == S_DOOR) ? w_floor_onehot : 4'b0000);
    // Clear is applied after set so it wins for the floor being served.
    assign w_clr = w_enter_door ? w_floor_onehot : 4'b0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_pending <= 4'b0000;
            r_rfloor  <= 2'd0;
            r_dir_up  <= 1'b1;
            r_served  <= 1'b0;
            r_dwell   <= 7'd0;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= (r_pending | w_set) & ~w_clr;
            r_rfloor  <= w_rfloor_nx;
            r_dir_up  <= w_dir_nx;
            r_served  <= w_enter_door;
            if ((r_state == S_DOOR) && (w_state_nx == S_DOOR)) begin
                r_dwell <= w_reload ? 7'd0 : r_dwell + 7'd1;
            end else begin
                r_dwell <= 7'd0;
            end
        end
    end

    assign rfloor    = r_rfloor;
    assign pending   = r_pending;
    assign dir_up    = r_dir_up;
    assign busy      = (r_state != S_IDLE);
    assign door_open = (r_state == S_DOOR);
    assign served    = r_served;

endmodule

// File: tb/tb_elevator_req_scheduler.sv
module tb_elevator_req_scheduler;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req_btn = 4'b0000;
    logic [1:0] car_floor = 2'd0;
    logic       car_stop = 1'b1;
    logic [1:0] rfloor;
    logic [3:0] pending;
    logic       dir_up;
    logic       busy;
    logic       door_open;
    logic       served;

    always #5 clk = ~clk;

    elevator_req_scheduler #(.DOOR_CYCLES(DC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_btn   (req_btn),
        .car_floor (car_floor),
        .car_stop  (car_stop),
        .rfloor    (rfloor),
        .pending   (pending),
        .dir_up    (dir_up),
        .busy      (busy),
        .door_open (door_open),
        .served    (served)
    );

    typedef struct packed {
        logic [1:0] rf;
        logic [3:0] pend;
        logic       up;
        logic       busy;
        logic       door;
        logic       srv;
    } snap_t;

    localparam snap_t RESET_SNAP = '{rf: 2'd0, pend: 4'b0000, up: 1'b1,
                                     busy: 1'b0, door: 1'b0, srv: 1'b0};

    snap_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
    mode_t m_mode = M_IDLE;
    bit    m_pend[4];
    int    m_rf = 0;
    bit    m_dup = 1'b1;
    int    m_timer = 0;
    bit    m_sv = 1'b0;

    // Nearest pending floor strictly above/below 'from', -1 when none.
    function automatic int nearest(input int from, input bit up);
        if (up) begin
            for (int f = from + 1; f <= 3; f++) if (m_pend[f]) return f;
        end else begin
            for (int f = from - 1; f >= 0; f--) if (m_pend[f]) return f;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : ref_model
        int    cf, tu, td, t, fwd, rev;
        bit    enter;
        mode_t prev;
        snap_t s;
        if (!reset_n) begin
            m_mode  = M_IDLE;
            for (int f = 0; f < 4; f++) m_pend[f] = 1'b0;
            m_rf    = 0;
            m_dup   = 1'b1;
            m_timer = 0;
            m_sv    = 1'b0;
        end else begin
            cf    = int'(car_floor);
            tu    = nearest(cf, 1'b1);
            td    = nearest(cf, 1'b0);
            enter = 1'b0;
            prev  = m_mode;
            case (m_mode)
                M_IDLE: begin
                    m_rf = cf;
                    if (m_pend[cf]) begin
                        m_mode = M_DOOR; enter = 1'b1;
                    end else if (tu >= 0) begin
                        m_mode = M_UP; m_rf = tu; m_dup = 1'b1;
                    end else if (td >= 0) begin
                        m_mode = M_DOWN; m_rf = td; m_dup = 1'b0;
                    end
                end
                M_UP, M_DOWN: begin
                    if (car_stop && cf == m_rf) begin
                        m_mode = M_DOOR; enter = 1'b1;
                    end else begin
                        t = (m_mode == M_UP) ? tu : td;
                        if (t >= 0) m_rf = t;
                    end
                end
                M_DOOR: begin
                    m_rf = cf;
                    if (req_btn[cf]) m_timer = DC;
                    else m_timer = m_timer - 1;
                    if (m_timer == 0) begin
                        fwd = m_dup ? tu : td;
                        rev = m_dup ? td : tu;
                        if (fwd >= 0) begin
                            m_mode = m_dup ? M_UP : M_DOWN; m_rf = fwd;
                        end else if (rev >= 0) begin
                            m_dup = !m_dup;
                            m_mode = m_dup ? M_UP : M_DOWN; m_rf = rev;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            if (enter) m_timer = DC;
            for (int f = 0; f < 4; f++)
                if (req_btn[f] && !(prev == M_DOOR && f == cf)) m_pend[f] = 1'b1;
            if (enter) m_pend[cf] = 1'b0;
            m_sv = enter;
        end
        s.rf   = 2'(m_rf);
        for (int f = 0; f < 4; f++) s.pend[f] = m_pend[f];
        s.up   = m_dup;
        s.busy = (m_mode != M_IDLE);
        s.door = (m_mode == M_DOOR);
        s.srv  = m_sv;
        exp_q.push_back(s);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        snap_t g, e;
        g = {rfloor, pending, dir_up, busy, door_open, served};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty t=%0t got rf=%0d pend=%b", $time, g.rf, g.pend);
        end else begin
            e = exp_q.pop_front();
            if (!reset_n) e = RESET_SNAP;
            if (g !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t got rf=%0d pend=%b up=%b busy=%b door=%b srv=%b exp rf=%0d pend=%b up=%b busy=%b door=%b srv=%b",
                         $time, g.rf, g.pend, g.up, g.busy, g.door, g.srv,
                         e.rf, e.pend, e.up, e.busy, e.door, e.srv);
            end
        end
    end

    // ---------------- car model: one floor per 8 cycles toward rfloor ----------------
    int car_cnt = 0;
    always @(negedge clk) begin : car_model
        if (!reset_n) begin
            car_cnt = 0;
        end else if (car_floor != rfloor) begin
            car_cnt++;
            if (car_cnt == 8) begin
                car_cnt = 0;
                car_floor = (rfloor > car_floor) ? car_floor + 2'd1 : car_floor - 2'd1;
            end
        end else begin
            car_cnt = 0;
        end
        car_stop = (car_floor == rfloor);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d exp %0d", name, $time, got, want);
        end
    endtask

    task automatic press(input logic [3:0] m, input int n);
        @(negedge clk);
        req_btn = m;
        repeat (n) @(negedge clk);
        req_btn = 4'b0000;
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        repeat (3) @(negedge clk);
        while ((busy || pending != 4'b0000) && k < max) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", int'(busy || pending != 4'b0000), 0);
    endtask

    task automatic wait_served(input int max);
        int k;
        k = 0;
        while (!served && k < max) begin
            @(negedge clk);
            k++;
        end
        check("served_seen", int'(served), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int door_n, sv_n, pend_bad, k;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("reset_pending", int'(pending), 0);
        check("reset_dir_up", int'(dir_up), 1);

        // Single call from floor 0 to floor 2.
        press(4'b0100, 1);
        check("s1_pending", int'(pending), 4);
        @(negedge clk);
        check("s1_rfloor", int'(rfloor), 2);
        check("s1_dir_up", int'(dir_up), 1);
        wait_served(200);
        door_n = 0;
        k = 0;
        while (door_open && k < 50) begin
            door_n++; k++;
            @(negedge clk);
        end
        check("s1_door_len", door_n, DC);
        check("s1_pending_after", int'(pending), 0);
        check("s1_idle", int'(busy), 0);

        press(4'b0001, 1);
        wait_idle(300);

        // Intermediate call retargets a car headed for floor 3.
        press(4'b1000, 1);
        @(negedge clk);
        check("s2_rfloor3", int'(rfloor), 3);
        press(4'b0010, 1);
        @(negedge clk);
        check("s2_retarget", int'(rfloor), 1);
        wait_served(200);
        check("s2_stop_at1", int'(rfloor), 1);
        wait_idle(300);
        check("s2_end_at3", int'(rfloor), 3);

        // Call at the current floor from idle at the top floor.
        press(4'b1000, 1);
        @(negedge clk);
        check("s6_door", int'(door_open), 1);
        check("s6_served", int'(served), 1);
        check("s6_rfloor", int'(rfloor), 3);
        check("s6_pending", int'(pending), 0);
        wait_idle(300);

        // Asynchronous reset in the middle of a downward move.
        press(4'b0001, 1);
        repeat (3) @(negedge clk);
        press(4'b1000, 1);
        check("s5_pending", int'(pending), 9);
        check("s5_dir_down", int'(dir_up), 0);
        #2 reset_n = 1'b0;
        #1;
        check("s5_rst_busy", int'(busy), 0);
        check("s5_rst_pending", int'(pending), 0);
        check("s5_rst_rfloor", int'(rfloor), 0);
        check("s5_rst_dir_up", int'(dir_up), 1);
        check("s5_rst_door", int'(door_open), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("s5_post_busy", int'(busy), 0);
        check("s5_post_pending", int'(pending), 0);

        // From floor 1 with calls at 0 and 3: up first, then reverse.
        press(4'b0010, 1);
        wait_idle(300);
        press(4'b1001, 1);
        @(negedge clk);
        check("s3_tie_dir", int'(dir_up), 1);
        check("s3_tie_rfloor", int'(rfloor), 3);
        wait_served(200);
        check("s3_first_stop", int'(rfloor), 3);
        k = 0;
        while (door_open && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("s3_reverse_dir", int'(dir_up), 0);
        check("s3_reverse_rfloor", int'(rfloor), 0);
        wait_idle(300);

        // Held call at the open door extends the dwell.
        press(4'b0100, 1);
        wait_served(200);
        door_n = 1; sv_n = 1; pend_bad = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (!door_open) break;
            door_n++;
            if (served) sv_n++;
            if (pending[2]) pend_bad++;
            req_btn = (j <= 3) ? 4'b0100 : 4'b0000;
        end
        req_btn = 4'b0000;
        check("s4_door_len", door_n, 8);
        check("s4_served_cnt", sv_n, 1);
        check("s4_pending2", pend_bad, 0);
        wait_idle(300);

        // Random call traffic.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            k = int'($urandom_range(0, 31));
            if (k == 0) req_btn = 4'($urandom);
            else if (k < 3) req_btn = 4'b0001 << $urandom_range(0, 3);
            else req_btn = 4'b0000;
        end
        @(negedge clk);
        req_btn = 4'b0000;
        wait_idle(600);
        @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
